// File: rtl/des_pkg.sv
// des_pkg: shared DES key-schedule constants, permutation tables, types and the 28-bit rotate helper.
package des_pkg;

    localparam int DES_NUM_ROUNDS = 16;
    localparam logic [15:0] DES_SHIFT_MASK = 16'h8103;

    typedef logic [55:0] cd_t;
    typedef logic [47:0] round_key_t;

    // Tables use DES numbering: entry i names the 1-based, MSB-first source bit of output bit i+1.
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // dir=1 rotates left, dir=0 rotates right; amount 0 returns value unchanged.
    function automatic logic [27:0] rot28(input logic [27:0] value, input logic [1:0] amount, input logic dir);
        logic [55:0] d;
        d = {value, value};
        return dir ? d[55-int'(amount) -: 28] : d[27+int'(amount) -: 28];
    endfunction

endpackage

// File: rtl/p_box_56_48.sv
// p_box_56_48: PC-2 compression permutation from the C/D halves to a 48-bit round key.
module p_box_56_48
    import des_pkg::*;
(
    input  cd_t        din,
    output round_key_t dout
);

    for (genvar i = 0; i < 48; i++) begin : g_bit
        assign dout[47-i] = din[56-PC2_TABLE[i]];
    end

endmodule

// File: rtl/p_box_64_56.sv
// p_box_64_56: PC-1 permutation, drops the eight parity bits of a raw DES key.
module p_box_64_56
    import des_pkg::*;
(
    input  logic [63:0] din,
    output cd_t         dout
);

    for (genvar i = 0; i < 56; i++) begin : g_bit
        assign dout[55-i] = din[64-PC1_TABLE[i]];
    end

endmodule

// File: rtl/des_key_scheduler.sv
// des_key_scheduler: iterative DES key schedule streaming one round key per cycle,
// in encrypt or decrypt order, with a valid/ready output handshake.
module des_key_scheduler
    import des_pkg::*;
#(
    parameter int                    NUM_ROUNDS = DES_NUM_ROUNDS,
    parameter logic [NUM_ROUNDS-1:0] SHIFT_MASK = DES_SHIFT_MASK,
    parameter int                    IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      key_in,
    input  logic             key_decrypt,
    input  logic             key_valid,
    output logic             key_ready,
    output round_key_t       round_key_out,
    output logic [IDX_W-1:0] round_idx,
    output logic             rk_last,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    cd_t              cd_reg, pc1_cd, cd_rot;
    round_key_t       pc2_rk;
    logic             mode;
    logic [IDX_W:0]   step;
    logic [IDX_W-1:0] sidx;
    logic [1:0]       sh;
    logic             load, done;

    p_box_64_56 u_pc1 (.din(key_in), .dout(pc1_cd));
    p_box_56_48 u_pc2 (.din(cd_rot), .dout(pc2_rk));

    // Decrypt walks the encrypt rotations backwards; step 0 emits K16 from the unrotated PC-1 value.
    assign sidx   = mode ? IDX_W'(NUM_ROUNDS - int'(step)) : step[IDX_W-1:0];
    assign sh     = (mode && step == '0) ? 2'd0 : (SHIFT_MASK[sidx] ? 2'd1 : 2'd2);
    assign cd_rot = {rot28(cd_reg[55:28], sh, !mode), rot28(cd_reg[27:0], sh, !mode)};

    assign key_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign load      = (state == RUN) && (!rk_valid || rk_ready) && (step < (IDX_W+1)'(NUM_ROUNDS));
    assign done      = rk_valid && rk_ready && rk_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == IDLE && key_valid) state_next = RUN;
        else if (state == RUN && done && !load) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_reg        <= '0;
            mode          <= 1'b0;
            step          <= '0;
            round_key_out <= '0;
            round_idx     <= '0;
            rk_last       <= 1'b0;
            rk_valid      <= 1'b0;
        end else if (key_valid && key_ready) begin
            cd_reg <= pc1_cd;
            mode   <= key_decrypt;
            step   <= '0;
        end else if (load) begin
            cd_reg        <= cd_rot;
            round_key_out <= pc2_rk;
            round_idx     <= step[IDX_W-1:0];
            rk_last       <= (step == (IDX_W+1)'(NUM_ROUNDS - 1));
            rk_valid      <= 1'b1;
            step          <= step + 1'b1;
        end else if (rk_valid && rk_ready) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
        end
    end

endmodule

// File: doc/des_key_scheduler.md
Name: des_key_scheduler

Overview:
Iterative, handshaked DES key schedule engine. It accepts one 64-bit key, applies PC-1, then streams all round keys one per cycle. Each round key is PC-2 of the rotated C/D halves. Unlike a per-round combinational key stage, it holds C/D state across rounds, supports encrypt (K1..K16) and decrypt (K16..K1) order, and tolerates consumer back-pressure. It sits between the key-load interface and the iterative Feistel round datapath.

Parameters:
NUM_ROUNDS, 16, number of round keys emitted per loaded key; must be 16 for DES-compliant output.
SHIFT_MASK, 16'h8103, bit r=1 means round r (0-based) rotates by 1; bit r=0 means it rotates by 2. Default gives rounds 0,1,8,15 single.
IDX_W, 4, width of round_idx; must satisfy 2**IDX_W >= NUM_ROUNDS.

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
key_in  input  64  raw DES key, parity bits included; PC-1 drops them
key_decrypt  input  1  sampled with key_in; 1 = emit keys in reverse order
key_valid  input  1  key_in/key_decrypt valid
key_ready  output  1  scheduler idle and able to accept a key
round_key_out  output  48  current round key (post PC-2)
round_idx  output  IDX_W  emission index j, 0..NUM_ROUNDS-1
rk_last  output  1  high with the final round key of the schedule
rk_valid  output  1  round_key_out/round_idx/rk_last valid
rk_ready  input  1  consumer accepts the current round key
busy  output  1  high from key acceptance until final round-key handshake

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, key_ready=1, rk_valid=0, rk_last=0, busy=0.
  - round_key_out=0, round_idx=0, internal cd_reg=0, step counter=0.
  - Reset mid-schedule aborts immediately; no partial output survives.
- Key acceptance:
  - Occurs only when key_valid && key_ready, i.e. only in IDLE.
  - Cycle T accept: cd_reg<=PC1(key_in), mode<=key_decrypt, step<=0, state<=RUN; key_ready drops at T+1.
- Shift amount for step j:
  - Encrypt: rotate left by s(j).
  - Decrypt: j=0 rotates 0; j>=1 rotates right by s(NUM_ROUNDS-j).
  - s(r) = SHIFT_MASK[r] ? 1 : 2.
  - C (cd[55:28]) and D (cd[27:0]) rotate independently as 28-bit fields.
- In RUN, the output register loads when (!rk_valid || rk_ready) and step<NUM_ROUNDS:
  - cd_reg<=rot(cd_reg)
  - round_key_out<=PC2(rot(cd_reg))
  - round_idx<=step
  - rk_last<=(step==NUM_ROUNDS-1)
  - rk_valid<=1
  - step<=step+1
- Latency and throughput:
  - First round key is valid at T+2.
  - With rk_ready tied high, keys appear in NUM_ROUNDS consecutive cycles, T+2..T+17.
- Back-pressure:
  - While rk_valid && !rk_ready, all outputs and cd_reg hold stable.
  - No key is skipped or duplicated.
- Completion:
  - On the handshake with rk_last=1 and no further load: rk_valid<=0, busy<=0, state<=IDLE.
  - key_ready=1 the following cycle; no same-cycle key re-accept.
- Decrypt correctness relies on the total rotation summing to 28, i.e. identity. Decrypt j=0 therefore emits PC2(PC1(key)) = K16.
- key_valid asserted while busy is ignored (key_ready=0) and has no side effects.
- busy=1 from T+1 through the cycle of the final handshake.

Decomposition:
- Package des_pkg:
  - DES_NUM_ROUNDS=16, DES_SHIFT_MASK=16'h8103
  - PC-1 and PC-2 index tables
  - typedef cd_t (56 bits), round_key_t (48 bits)
  - function rot28(value, amount, dir)
- Sub-modules:
  - Reuse the existing p_box_56_48 for PC-2.
  - Add one natural sub-module, p_box_64_56, for PC-1.
  - FSM, counter and output register stay in des_key_scheduler.

Test Plan:
- Encrypt, rk_ready=1, key_in=64'h133457799BBCDFF1, key_decrypt=0:
  - cd after PC-1 = 56'hF0CCAAF556678F.
  - idx0 = 48'h1B02EFFC7072 at T+2.
  - idx15 = 48'hCB3D8B0E17F5 with rk_last=1 at T+17; busy low after.
- Decrypt, same key, key_decrypt=1:
  - idx0 = 48'hCB3D8B0E17F5.
  - idx15 = 48'h1B02EFFC7072 with rk_last.
  - The full 16-key sequence equals the encrypt sequence reversed.
- Back-pressure:
  - Drive rk_ready with a random ~50% pattern during encrypt of the same key.
  - Outputs stay stable while stalled; exactly 16 handshakes occur, matching the reference sequence in order.
- Key during busy:
  - Pulse key_valid with key 64'h0 at step 5.
  - key_ready=0 and the schedule is unaffected; the next key is accepted only after key_ready returns to 1.
- Reset mid-schedule:
  - Assert rst_n=0 asynchronously at step 7.
  - All outputs clear immediately (rk_valid=0, key_ready=1 after release).
  - A fresh load then reproduces idx0 = 48'h1B02EFFC7072.
- Back-to-back keys with rk_ready=1:
  - Exactly one idle cycle separates the rk_last handshake from the next acceptance.
  - The second key's sequence is correct.
